// File: rtl/mcpu_core.sv
// mcpu_core: multicycle MIPS-subset core with req/ack instruction and data ports.
// Supports add/sub/and/or/slt, addi, lw, sw, beq and j. Any other opcode or funct halts the core.
// im_req, dm_req, dm_we, dm_addr, dm_wdata, retire and halted are registered.
// retire is high in the cycle right after an instruction's final clock edge.
module mcpu_core #(
  parameter int          ADDR_W   = 32,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic              clk,
  input  logic              reset,
  output logic              im_req,
  output logic [ADDR_W-1:0] im_addr,
  input  logic [31:0]       im_rdata,
  input  logic              im_ack,
  output logic              dm_req,
  output logic              dm_we,
  output logic [ADDR_W-1:0] dm_addr,
  output logic [31:0]       dm_wdata,
  input  logic [31:0]       dm_rdata,
  input  logic              dm_ack,
  output logic [ADDR_W-1:0] pc_out,
  output logic              retire,
  output logic              halted
);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] FN_ADD   = 6'h20;
  localparam logic [5:0] FN_SUB   = 6'h22;
  localparam logic [5:0] FN_AND   = 6'h24;
  localparam logic [5:0] FN_OR    = 6'h25;
  localparam logic [5:0] FN_SLT   = 6'h2A;

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
  } state_t;

  state_t             state;
  logic [ADDR_W-1:0]  pc;
  logic [ADDR_W-1:0]  target;
  logic [31:0]        ir;
  logic [31:0]        mdr;
  logic signed [31:0] a;
  logic signed [31:0] b;
  logic signed [31:0] alu_out;
  logic [31:0]        regs [32];

  function automatic logic signed [31:0] sext16(input logic [15:0] v);
    return {{16{v[15]}}, v};
  endfunction

  function automatic logic [31:0] alu_r(input logic [5:0] fn,
                                        input logic signed [31:0] x,
                                        input logic signed [31:0] y);
    case (fn)
      FN_ADD:  return x + y;
      FN_SUB:  return x - y;
      FN_AND:  return x & y;
      FN_OR:   return x | y;
      FN_SLT:  return {31'b0, (x < y)};
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic is_legal(input logic [5:0] o, input logic [5:0] fn);
    case (o)
      OP_RTYPE: return (fn == FN_ADD) || (fn == FN_SUB) || (fn == FN_AND) ||
                       (fn == FN_OR)  || (fn == FN_SLT);
      OP_ADDI, OP_LW, OP_SW, OP_BEQ, OP_J: return 1'b1;
      default:  return 1'b0;
    endcase
  endfunction

  logic [5:0]         op;
  logic [5:0]         funct;
  logic [4:0]         rs;
  logic [4:0]         rt;
  logic [4:0]         rd;
  logic signed [31:0] imm_s;
  logic signed [31:0] ea;
  logic [31:0]        br_off;
  logic [31:0]        pc32;
  logic [31:0]        tgt32;
  logic [31:0]        jt;
  logic [4:0]         wb_dst;
  logic [31:0]        wb_data;

  assign op      = ir[31:26];
  assign rs      = ir[25:21];
  assign rt      = ir[20:16];
  assign rd      = ir[15:11];
  assign funct   = ir[5:0];
  assign imm_s   = sext16(ir[15:0]);
  assign ea      = a + imm_s;
  assign br_off  = imm_s << 2;
  assign pc32    = 32'(pc);
  assign tgt32   = pc32 + br_off;
  // Jump keeps the top nibble of the already-incremented PC (zero when ADDR_W <= 28).
  assign jt      = (pc32 & 32'hF000_0000) | {4'b0, ir[25:0], 2'b00};
  assign wb_dst  = (op == OP_RTYPE) ? rd : rt;
  assign wb_data = (op == OP_LW) ? mdr : alu_out;

  assign im_addr = pc;
  assign pc_out  = pc;

  // Control FSM with datapath registers, register file and registered memory-port outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= S_FETCH;
      pc       <= RESET_PC[ADDR_W-1:0];
      target   <= '0;
      ir       <= '0;
      mdr      <= '0;
      a        <= '0;
      b        <= '0;
      alu_out  <= '0;
      im_req   <= 1'b0;
      dm_req   <= 1'b0;
      dm_we    <= 1'b0;
      dm_addr  <= '0;
      dm_wdata <= '0;
      retire   <= 1'b0;
      halted   <= 1'b0;
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else begin
      retire <= 1'b0;
      case (state)
        S_FETCH: begin
          if (!im_req) begin
            im_req <= 1'b1;
          end else if (im_ack) begin
            ir     <= im_rdata;
            pc     <= pc + ADDR_W'(4);
            im_req <= 1'b0;
            state  <= S_DECODE;
          end
        end
        S_DECODE: begin
          a      <= regs[rs];
          b      <= regs[rt];
          target <= tgt32[ADDR_W-1:0];
          if (is_legal(op, funct)) begin
            state <= S_EXEC;
          end else begin
            state  <= S_HALT;
            halted <= 1'b1;
          end
        end
        S_EXEC: begin
          case (op)
            OP_RTYPE: begin
              alu_out <= alu_r(funct, a, b);
              state   <= S_WB;
            end
            OP_ADDI: begin
              alu_out <= ea;
              state   <= S_WB;
            end
            OP_LW, OP_SW: begin
              alu_out  <= ea;
              dm_req   <= 1'b1;
              dm_we    <= (op == OP_SW);
              dm_addr  <= ea[ADDR_W-1:0];
              dm_wdata <= b;
              state    <= S_MEM;
            end
            OP_BEQ: begin
              if (a == b) pc <= target;
              im_req <= 1'b1;
              retire <= 1'b1;
              state  <= S_FETCH;
            end
            OP_J: begin
              pc     <= jt[ADDR_W-1:0];
              im_req <= 1'b1;
              retire <= 1'b1;
              state  <= S_FETCH;
            end
            default: begin
              state  <= S_HALT;
              halted <= 1'b1;
            end
          endcase
        end
        S_MEM: begin
          if (dm_ack) begin
            dm_req <= 1'b0;
            dm_we  <= 1'b0;
            if (op == OP_SW) begin
              im_req <= 1'b1;
              retire <= 1'b1;
              state  <= S_FETCH;
            end else begin
              mdr   <= dm_rdata;
              state <= S_WB;
            end
          end
        end
        S_WB: begin
          if (wb_dst != 5'd0) regs[wb_dst] <= wb_data;
          im_req <= 1'b1;
          retire <= 1'b1;
          state  <= S_FETCH;
        end
        default: begin
          halted <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mcpu_core.sv
// tb_mcpu_core: directed bench for mcpu_core with wait-state memory models.
module tb_mcpu_core;

  localparam logic [31:0] ILL  = 32'hFC00_0000;
  localparam logic [31:0] NOP  = 32'h0000_0020;
  localparam logic [31:0] SENT = 32'hDEAD_BEEF;

  logic        clk;
  logic        reset;
  logic        im_req, im_ack, dm_req, dm_we, dm_ack, retire, halted;
  logic [31:0] im_addr, im_rdata, dm_addr, dm_wdata, dm_rdata, pc_out;

  logic [31:0] imem [512];
  logic [31:0] dmem [64];
  int          im_wait, dm_wait, im_cnt, dm_cnt;
  logic        dm_clr;
  int          wr_cnt;
  int          cyc;
  int          ret_n, fa_n;
  int          ret_cyc [2048];
  logic [31:0] fa [2048];
  int          checks, errors;

  mcpu_core #(.ADDR_W(32), .RESET_PC(32'h40)) dut (
    .clk(clk), .reset(reset),
    .im_req(im_req), .im_addr(im_addr), .im_rdata(im_rdata), .im_ack(im_ack),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata), .dm_ack(dm_ack),
    .pc_out(pc_out), .retire(retire), .halted(halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign im_rdata = imem[im_addr[10:2]];
  assign im_ack   = im_req && (im_cnt >= im_wait);
  assign dm_rdata = dmem[dm_addr[7:2]];
  assign dm_ack   = dm_req && (dm_cnt >= dm_wait);

  // Memory models: count wait cycles, perform stores, log fetches and retirements.
  initial begin
    im_cnt = 0; dm_cnt = 0; wr_cnt = 0; cyc = 0; ret_n = 0; fa_n = 0;
  end
  always @(posedge clk) begin
    im_cnt <= (im_req && !im_ack) ? im_cnt + 1 : 0;
    dm_cnt <= (dm_req && !dm_ack) ? dm_cnt + 1 : 0;
    cyc    <= cyc + 1;
    if (dm_clr) begin
      for (int k = 0; k < 64; k++) dmem[k] <= SENT;
    end else if (dm_req && dm_ack && dm_we) begin
      dmem[dm_addr[7:2]] <= dm_wdata;
      wr_cnt <= wr_cnt + 1;
    end
    if (retire && ret_n < 2048) begin
      ret_cyc[ret_n] <= cyc;
      ret_n <= ret_n + 1;
    end
    if (im_req && im_ack && fa_n < 2048) begin
      fa[fa_n] <= im_addr;
      fa_n <= fa_n + 1;
    end
  end

  function automatic logic [31:0] enc_r(int rs, int rt, int rd, logic [5:0] fn);
    return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'd0, fn};
  endfunction
  function automatic logic [31:0] enc_i(logic [5:0] op, int rs, int rt, logic [15:0] imm);
    return {op, 5'(rs), 5'(rt), imm};
  endfunction
  function automatic logic [31:0] enc_j(logic [25:0] idx);
    return {6'h02, idx};
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic enter_reset();
    @(negedge clk);
    reset  = 1'b0;
    dm_clr = 1'b1;
    @(negedge clk);
    dm_clr = 1'b0;
    for (int k = 0; k < 512; k++) imem[k] = ILL;
  endtask

  task automatic release_reset();
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic wait_halt(input string nm, input int lim);
    int n;
    n = 0;
    while (!halted && n < lim) begin
      @(negedge clk);
      n++;
    end
    check({nm, "_halt_reached"}, {31'b0, halted}, 32'd1);
  endtask

  task automatic wait_dmreq(input string nm, input int lim);
    int n;
    n = 0;
    while (!dm_req && n < lim) begin
      @(negedge clk);
      n++;
    end
    check({nm, "_dm_req_seen"}, {31'b0, dm_req}, 32'd1);
  endtask

  typedef struct {
    logic [31:0] i0;
    logic [31:0] i1;
    int          iw;
    logic [31:0] exp;
  } vec_t;
  vec_t vt [13];

  initial begin
    int r0, f0, wc0, n;
    logic ok;
    checks = 0; errors = 0;
    im_wait = 0; dm_wait = 0; dm_clr = 1'b0;
    for (int k = 0; k < 512; k++) imem[k] = ILL;

    // $1=5, $2=7, $4=-2 precomputed; i0/i1 leave their result in $10
    vt[0]  = '{enc_r(1, 2, 10, 6'h20), NOP, 0, 32'd12};
    vt[1]  = '{enc_r(1, 2, 10, 6'h22), NOP, 1, 32'hFFFF_FFFE};
    vt[2]  = '{enc_r(1, 2, 10, 6'h24), NOP, 0, 32'd5};
    vt[3]  = '{enc_r(1, 2, 10, 6'h25), NOP, 2, 32'd7};
    vt[4]  = '{enc_r(1, 2, 10, 6'h2A), NOP, 0, 32'd1};
    vt[5]  = '{enc_r(2, 1, 10, 6'h2A), NOP, 0, 32'd0};
    vt[6]  = '{enc_r(1, 4, 10, 6'h2A), NOP, 1, 32'd0};
    vt[7]  = '{enc_r(4, 1, 10, 6'h2A), NOP, 0, 32'd1};
    vt[8]  = '{enc_i(6'h08, 1, 10, 16'hFFFF), NOP, 0, 32'd4};
    vt[9]  = '{enc_i(6'h08, 0, 0, 16'd9), enc_r(0, 0, 10, 6'h20), 0, 32'd0};
    vt[10] = '{enc_i(6'h08, 4, 10, 16'h7FFF), NOP, 3, 32'h0000_7FFD};
    vt[11] = '{enc_r(4, 4, 10, 6'h20), NOP, 0, 32'hFFFF_FFFC};
    vt[12] = '{enc_r(4, 1, 10, 6'h22), NOP, 0, 32'hFFFF_FFF9};

    reset = 1'b1;
    #2 reset = 1'b0;

    // Reset state and main arithmetic / load-store program
    enter_reset();
    imem[16] = enc_i(6'h08, 0, 1, 16'd5);
    imem[17] = enc_i(6'h08, 0, 2, 16'd7);
    imem[18] = enc_r(1, 2, 3, 6'h20);
    imem[19] = enc_r(1, 2, 4, 6'h22);
    imem[20] = enc_r(4, 0, 5, 6'h2A);
    imem[21] = enc_i(6'h2B, 0, 3, 16'h0008);
    imem[22] = enc_i(6'h23, 0, 6, 16'h0008);
    imem[23] = enc_i(6'h2B, 0, 4, 16'h0010);
    imem[24] = enc_i(6'h2B, 0, 5, 16'h0014);
    imem[25] = enc_i(6'h2B, 0, 6, 16'h0018);
    dm_wait = 3;
    @(negedge clk);
    check("rst_im_req", {31'b0, im_req}, 32'd0);
    check("rst_dm_req", {31'b0, dm_req}, 32'd0);
    check("rst_dm_we", {31'b0, dm_we}, 32'd0);
    check("rst_retire", {31'b0, retire}, 32'd0);
    check("rst_halted", {31'b0, halted}, 32'd0);
    check("rst_pc", pc_out, 32'h40);
    r0 = ret_n;
    release_reset();
    @(posedge clk); #1;
    check("first_im_req", {31'b0, im_req}, 32'd1);
    check("first_im_addr", im_addr, 32'h40);
    @(posedge clk); #1;
    check("pc_after_ack", pc_out, 32'h44);
    wait_dmreq("sw_wait", 100);
    n = 0; ok = 1'b1;
    while (dm_req && n < 20) begin
      if (dm_addr !== 32'd8 || dm_wdata !== 32'd12 || dm_we !== 1'b1) ok = 1'b0;
      n++;
      @(negedge clk);
    end
    check("sw_dm_req_cycles", n, 32'd4);
    check("sw_dm_stable", {31'b0, ok}, 32'd1);
    wait_halt("main", 400);
    check("mem_r3", dmem[2], 32'd12);
    check("mem_r4", dmem[4], 32'hFFFF_FFFE);
    check("mem_r5", dmem[5], 32'd1);
    check("mem_r6_lw", dmem[6], 32'd12);
    check("retire_count", ret_n - r0, 32'd10);
    for (int k = 1; k < 5; k++)
      check($sformatf("alu_spacing%0d", k), ret_cyc[r0+k] - ret_cyc[r0+k-1], 32'd4);
    check("sw_latency_w3", ret_cyc[r0+5] - ret_cyc[r0+4], 32'd7);
    check("lw_latency_w3", ret_cyc[r0+6] - ret_cyc[r0+5], 32'd8);
    check("halt_pc", pc_out, 32'h6C);
    n = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (im_req || dm_req) n++;
    end
    check("halt_no_req_20", n, 32'd0);
    check("halt_still", {31'b0, halted}, 32'd1);

    // Branches and jumps
    enter_reset();
    imem[16] = enc_i(6'h08, 0, 1, 16'd5);
    imem[17] = enc_i(6'h08, 0, 2, 16'd7);
    imem[18] = enc_j(26'd4);
    imem[4]  = enc_i(6'h04, 1, 1, 16'd2);
    imem[7]  = enc_i(6'h04, 1, 2, 16'd1);
    imem[8]  = enc_j(26'h100);
    dm_wait = 0; im_wait = 0;
    r0 = ret_n; f0 = fa_n;
    release_reset();
    wait_halt("branch", 200);
    check("fetch_count", fa_n - f0, 32'd7);
    check("fetch0", fa[f0+0], 32'h40);
    check("fetch2", fa[f0+2], 32'h48);
    check("j_to_0x10", fa[f0+3], 32'h10);
    check("beq_taken", fa[f0+4], 32'h1C);
    check("beq_not_taken", fa[f0+5], 32'h20);
    check("j_0x100", fa[f0+6], 32'h400);
    check("branch_halt_pc", pc_out, 32'h404);
    check("j_latency", ret_cyc[r0+2] - ret_cyc[r0+1], 32'd3);
    check("beq_t_latency", ret_cyc[r0+3] - ret_cyc[r0+2], 32'd3);
    check("beq_nt_latency", ret_cyc[r0+4] - ret_cyc[r0+3], 32'd3);

    // Table of single-instruction ALU vectors
    for (int v = 0; v < 13; v++) begin
      enter_reset();
      imem[16] = enc_i(6'h08, 0, 1, 16'd5);
      imem[17] = enc_i(6'h08, 0, 2, 16'd7);
      imem[18] = enc_r(1, 2, 4, 6'h22);
      imem[19] = vt[v].i0;
      imem[20] = vt[v].i1;
      imem[21] = enc_i(6'h2B, 0, 10, 16'h0020);
      im_wait = vt[v].iw; dm_wait = 1;
      release_reset();
      wait_halt($sformatf("vec%0d", v), 300);
      check($sformatf("vec%0d_result", v), dmem[8], vt[v].exp);
    end
    im_wait = 0;

    // Reset during the data wait of a store
    enter_reset();
    imem[16] = enc_i(6'h08, 0, 1, 16'd5);
    imem[17] = enc_i(6'h2B, 0, 1, 16'h0030);
    dm_wait = 10;
    release_reset();
    wait_dmreq("rst_mid", 100);
    @(negedge clk);
    @(negedge clk);
    wc0 = wr_cnt;
    #2 reset = 1'b0;
    #1;
    check("rst_mid_dm_req", {31'b0, dm_req}, 32'd0);
    check("rst_mid_dm_we", {31'b0, dm_we}, 32'd0);
    repeat (3) @(negedge clk);
    check("rst_mid_no_write", wr_cnt - wc0, 32'd0);
    check("rst_mid_mem", dmem[12], SENT);
    check("rst_mid_pc", pc_out, 32'h40);
    dm_wait = 0;
    release_reset();
    @(posedge clk); #1;
    check("refetch_req", {31'b0, im_req}, 32'd1);
    check("refetch_addr", im_addr, 32'h40);
    wait_halt("rst_mid_rerun", 100);
    check("rst_mid_rerun_mem", dmem[12], 32'd5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

endmodule
